// File: rtl/flit_inject_buffer.sv
// flit_inject_buffer: local-injection stage of the bufferless multicast router.
// Queues PE/NI flits in a small FIFO and presents the head flit to the router's
// input pipeline register. The head is consumed only in a cycle where the router
// reports a free output slot. The block counts how long the head has waited and
// raises a starvation flag for the throttling logic.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset (0 = reset)
//   in_valid   PE offers a flit
//   in_ready   buffer accepts a flit this cycle (count < DEPTH)
//   in_flit    flit from the PE, sampled only on a push
//   slot_free  router has a free output port this cycle
//   out_valid  head flit available for injection
//   out_flit   head flit, or all-zero when empty
//   out_age    number of cycles the current head has been blocked
//   count      FIFO occupancy
//   starve     head blocked for at least STARVE_TH cycles
module flit_inject_buffer #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AGE_W     = 8,
    parameter int unsigned STARVE_TH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_flit,
    input  logic                     slot_free,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_flit,
    output logic [AGE_W-1:0]         out_age,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     starve
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;
    localparam logic [AGE_W-1:0] TH_C    = AGE_W'(STARVE_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [AGE_W-1:0] age_q, age_d;
    logic             starve_q;
    logic             push, pop;

    // No cut-through: a full buffer refuses a push even when a pop happens.
    assign in_ready  = (count_q != DEPTH_C);
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & slot_free;

    // Memory is never reset, so gate the read with out_valid to keep X off the port.
    assign out_flit  = out_valid ? mem[rd_ptr_q] : '0;
    assign out_age   = age_q;
    assign count     = count_q;
    assign starve    = starve_q;

    // Age of the head: cleared by a pop or an empty buffer, otherwise counts
    // blocked cycles and saturates.
    always_comb begin
        age_d = age_q;
        if (pop || !out_valid) begin
            age_d = '0;
        end else if (!slot_free && (age_q != AGE_MAX)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            starve_q <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            age_q    <= age_d;
            starve_q <= (age_d >= TH_C);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr_q] <= in_flit;
        end
    end

endmodule

// File: tb/tb_flit_inject_buffer.sv
// Self-checking bench for flit_inject_buffer. Directed sequences followed by
// random traffic; every cycle's outputs are compared to a queue-based model.
// A second instance with a narrow age counter exercises saturation.
module tb_flit_inject_buffer;

    localparam int W   = 64;
    localparam int D   = 4;
    localparam int AW  = 8;
    localparam int TH  = 16;
    localparam int AW4 = 4;
    localparam int TH4 = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset, in_valid, slot_free;
    logic [W-1:0]   in_flit;
    logic           in_ready, out_valid, starve;
    logic [W-1:0]   out_flit;
    logic [AW-1:0]  out_age;
    logic [2:0]     count;
    logic           in_ready4, out_valid4, starve4;
    logic [W-1:0]   out_flit4;
    logic [AW4-1:0] out_age4;
    logic [2:0]     count4;

    flit_inject_buffer #(.WIDTH(W), .DEPTH(D), .AGE_W(AW), .STARVE_TH(TH)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .slot_free(slot_free), .out_valid(out_valid),
        .out_flit(out_flit), .out_age(out_age), .count(count), .starve(starve)
    );

    flit_inject_buffer #(.WIDTH(W), .DEPTH(D), .AGE_W(AW4), .STARVE_TH(TH4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .in_flit(in_flit), .slot_free(slot_free), .out_valid(out_valid4),
        .out_flit(out_flit4), .out_age(out_age4), .count(count4), .starve(starve4)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queue contents plus blocked-cycle counts of the head.
    logic [W-1:0] mq[$];
    int           mage  = 0;
    int           mage4 = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [W-1:0] head;
        int sz;
        sz   = mq.size();
        head = '0;
        if (sz != 0) head = mq[0];
        check("out_valid", 64'(out_valid), 64'(sz != 0));
        check("in_ready",  64'(in_ready),  64'(sz < D));
        check("out_flit",  out_flit,       head);
        check("count",     64'(count),     64'(sz));
        check("out_age",   64'(out_age),   64'(mage));
        check("starve",    64'(starve),    64'(mage >= TH));
        check("flit4",     out_flit4,      head);
        check("age4",      64'(out_age4),  64'(mage4));
        check("starve4",   64'(starve4),   64'(mage4 >= TH4));
    endtask

    // Drive one cycle: apply inputs at negedge, check the current outputs,
    // then advance the model across the coming posedge.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] f, input logic sf);
        bit push, pop, empty;
        @(negedge clk);
        reset     = r;
        in_valid  = iv;
        in_flit   = f;
        slot_free = sf;
        #1;
        compare_all();
        if (!r) begin
            mq.delete();
            mage  = 0;
            mage4 = 0;
        end else begin
            empty = (mq.size() == 0);
            push  = iv && (mq.size() < D);
            pop   = !empty && sf;
            if (pop || empty) begin
                mage  = 0;
                mage4 = 0;
            end else if (!sf) begin
                if (mage  < (1 << AW)  - 1) mage++;
                if (mage4 < (1 << AW4) - 1) mage4++;
            end
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(f);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 2 * D && mq.size() != 0; k++) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int thr;
        // Reset held for two edges with a flit offered.
        reset     = 1'b0;
        in_valid  = 1'b1;
        in_flit   = 64'hDEAD;
        slot_free = 1'b0;
        repeat (2) @(posedge clk);
        step(1'b0, 1'b1, 64'hFF, 1'b1);
        step(1'b1, 1'b1, 64'hA1, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        drain();

        // Fill to full, refused fifth push, drain in order.
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b1, 64'(i), 1'b0);
        step(1'b1, 1'b1, 64'h05, 1'b0);
        repeat (4) step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Simultaneous push/pop at count 2, then at count 4 (push refused).
        step(1'b1, 1'b1, 64'h10, 1'b0);
        step(1'b1, 1'b1, 64'h11, 1'b0);
        step(1'b1, 1'b1, 64'h12, 1'b1);
        step(1'b1, 1'b1, 64'h13, 1'b0);
        step(1'b1, 1'b1, 64'h14, 1'b0);
        step(1'b1, 1'b1, 64'h99, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);
        drain();
        // Push and pop at count 1.
        step(1'b1, 1'b1, 64'h15, 1'b0);
        step(1'b1, 1'b1, 64'h16, 1'b1);
        drain();

        // Wrap-around stream with alternating slot_free.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 64'h20 + 64'(i), 1'(i % 2));
        drain();

        // Age, starve and saturation of the narrow instance.
        step(1'b1, 1'b1, 64'h30, 1'b0);
        repeat (20) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b1);
        step(1'b1, 1'b0, '0, 1'b0);

        // Reset mid-operation while starving, with push and pop offered.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 64'h40 + 64'(i), 1'b0);
        repeat (17) step(1'b1, 1'b0, '0, 1'b0);
        step(1'b0, 1'b1, 64'h77, 1'b1);
        step(1'b1, 1'b1, 64'h55, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        drain();

        // Random traffic in phases of varying router congestion.
        for (int p = 0; p < 20; p++) begin
            thr = int'($urandom_range(0, 100));
            for (int c = 0; c < 150; c++) begin
                step(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 99) < 60),
                     {$urandom, $urandom}, 1'(int'($urandom_range(0, 99)) < thr));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flit_inject_buffer.md
Name: flit_inject_buffer

Overview:
- Local-injection stage of the bufferless multicast router.
- Queues flits from the attached PE/NI in a small FIFO.
- Presents the head flit to the router's input pipeline register (the DFF stage). The flit is consumed only when the router signals a free output slot this cycle.
- Tracks how long the head flit has waited and raises a starvation flag for the throttling logic.

Parameters:
- WIDTH, 64, flit width in bits.
- DEPTH, 4, FIFO entries; power of 2, ≥2.
- AGE_W, 8, width of the head-wait counter.
- STARVE_TH, 16, head-wait cycle count at which `starve` asserts; must be < 2^AGE_W.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous active-low reset; sampled on posedge clk, 0 = reset.
- in_valid  in  1  PE offers a flit.
- in_ready  out  1  buffer accepts a flit this cycle.
- in_flit  in  WIDTH  flit from PE.
- slot_free  in  1  router has a free output port this cycle; injection allowed.
- out_valid  out  1  head flit available for injection.
- out_flit  out  WIDTH  head flit, to pipeline-register data input.
- out_age  out  AGE_W  cycles the current head has been blocked.
- count  out  $clog2(DEPTH)+1  occupancy.
- starve  out  1  head blocked ≥ STARVE_TH cycles.

Behaviour:
- **Reset:** While reset==0 at posedge clk, the following are cleared: rd/wr pointers, count, out_age register, starve. Memory contents are don't-care. After reset:
  - out_valid=0, out_flit=0, in_ready=1, count=0, out_age=0, starve=0.
  - Reset mid-operation discards all queued flits and ignores any push/pop in that cycle.
- **Handshakes:**
  - push = in_valid & in_ready.
  - pop = out_valid & slot_free.
  - Both take effect on the same posedge.
- **in_ready:** = (count < DEPTH), combinational from registered count. No cut-through when full: a push is refused while full even if a pop occurs in the same cycle.
- **out_valid:** = (count != 0).
- **out_flit:** = mem[rd_ptr] when out_valid, else all-zero.
- **Latency:** a pushed flit is visible on out_flit one cycle after the push edge. There is no empty-FIFO bypass.
- **Counters and pointers:**
  - count: push only +1; pop only −1; both 0 change.
  - Pointers wrap modulo DEPTH with no special case.
- **Simultaneous push & pop when count==1:** the old head leaves and the new flit becomes head next cycle. out_valid stays 1.
- **Age counter:**
  - Clears to 0 on any pop, and while count==0.
  - Otherwise increments by 1 each cycle out_valid & ~slot_free.
  - Saturates at 2^AGE_W−1 with no wrap.
  - Holds when out_valid & slot_free is false for any other reason.
- **starve:** registered, = (next out_age ≥ STARVE_TH). Deasserts the cycle after the pop that clears the age.
- **Protocol:** no X on outputs in any state. in_flit is only sampled on a push.

Test Plan:
1. **Reset:** reset=0 for 2 cycles with in_valid=1 → out_valid=0, count=0, in_ready=1, out_flit=0. After reset=1, push 0xA1 → out_valid=1, out_flit=0xA1 the following cycle.
2. **Fill/full:**
   - Push 0x01..0x04 with slot_free=0 → count=4, in_ready=0.
   - Fifth push of 0x05 is not accepted; count stays 4.
   - Then slot_free=1 for 4 cycles → outputs 0x01,0x02,0x03,0x04 in order, count=0, out_valid=0.
3. **Simultaneous push/pop:**
   - With count=2 (0x10,0x11), push 0x12 with slot_free=1 → count stays 2, next head 0x11.
   - At count=4 with push+pop → push refused, count=3.
4. **Wrap-around:** stream 10 flits 0x20..0x29 with alternating slot_free → all 10 emitted in order, no loss/duplication, pointers wrap twice.
5. **Age/starve:**
   - Push 0x30, slot_free=0 for 20 cycles → out_age counts 0..19 (one step per cycle); starve rises when out_age reaches 16.
   - slot_free=1 → pop; next cycle out_age=0, starve=0.
   - AGE_W=4 variant: hold 20 cycles → out_age saturates at 15.
6. **Reset mid-operation:** count=3, starve=1, assert reset=0 one cycle with push+pop → count=0, starve=0, out_valid=0. The next pushed flit is the sole output.
